// File: rtl/writeback_commit.sv
// Writeback/commit stage: owns the register file and scoreboard, counts retirements, halts on kill.
// Latency 1 cycle (commit visible the cycle after accept); ready drops only once halted, and only reset exits halt.
module writeback_commit #(
    parameter int NUM_REGS     = 16,
    parameter int REG_IDX_W    = 4,
    parameter int DATA_W       = 64,
    parameter int NUM_WB_PORTS = 2,
    parameter int NUM_SRC      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wbValidIn,
    output logic                              wbReadyOut,
    input  logic                              killIn,
    input  logic [63:0]                       currentRipIn,
    input  logic [NUM_SRC*REG_IDX_W-1:0]      srcRegIn,
    input  logic [NUM_SRC-1:0]                srcValidIn,
    input  logic [NUM_WB_PORTS*REG_IDX_W-1:0] destRegIn,
    input  logic [NUM_WB_PORTS-1:0]           destValidIn,
    input  logic [NUM_WB_PORTS*DATA_W-1:0]    resultIn,
    input  logic                              reserveValidIn,
    input  logic [NUM_REGS-1:0]               reserveMaskIn,
    output logic [NUM_REGS*DATA_W-1:0]        regFileOut,
    output logic [NUM_REGS-1:0]               regInUseOut,
    output logic                              retireValidOut,
    output logic [63:0]                       retireRipOut,
    output logic [31:0]                       retireCountOut,
    output logic                              haltedOut
);

    if (NUM_REGS > 2**REG_IDX_W) begin : g_bad_params
        $error("NUM_REGS does not fit in REG_IDX_W bits");
    end

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] inuse_q;
    logic [NUM_REGS-1:0] inuse_d;
    logic [NUM_REGS-1:0] release_mask;
    logic                retire_vld_q;
    logic [63:0]         retire_rip_q;
    logic [31:0]         retire_cnt_q;
    logic                accept;

    assign accept = wbValidIn && (state_q == ST_RUN);

    // Decode per register rather than index the array, so out-of-range indices match nothing.
    always_comb begin
        release_mask = '0;
        regs_d       = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (accept && srcValidIn[s] &&
                    srcRegIn[s*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r)) begin
                    release_mask[r] = 1'b1;
                end
            end
            // Ascending port order: the highest matching port's result lands last.
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (accept && destValidIn[p] &&
                    destRegIn[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r)) begin
                    release_mask[r] = 1'b1;
                    regs_d[r]       = resultIn[p*DATA_W +: DATA_W];
                end
            end
        end
        inuse_d = inuse_q & ~release_mask;
        if (reserveValidIn && state_q == ST_RUN) begin
            inuse_d = inuse_d | reserveMaskIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            inuse_q      <= '0;
            retire_vld_q <= 1'b0;
            retire_rip_q <= '0;
            retire_cnt_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q       <= regs_d;
            inuse_q      <= inuse_d;
            retire_vld_q <= accept;
            if (accept) begin
                retire_rip_q <= currentRipIn;
                retire_cnt_q <= retire_cnt_q + 32'd1;
                if (killIn) begin
                    state_q <= ST_HALTED;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rf_out
        assign regFileOut[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign regInUseOut    = inuse_q;
    assign retireValidOut = retire_vld_q;
    assign retireRipOut   = retire_rip_q;
    assign retireCountOut = retire_cnt_q;
    assign wbReadyOut     = (state_q == ST_RUN);
    assign haltedOut      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_writeback_commit.sv
// Self-checking bench for writeback_commit: directed cases plus random traffic against a behavioural model.
module tb_writeback_commit;

    localparam int NR = 12;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int NP = 2;
    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wbValidIn;
    logic              wbReadyOut;
    logic              killIn;
    logic [63:0]       currentRipIn;
    logic [NS*IW-1:0]  srcRegIn;
    logic [NS-1:0]     srcValidIn;
    logic [NP*IW-1:0]  destRegIn;
    logic [NP-1:0]     destValidIn;
    logic [NP*DW-1:0]  resultIn;
    logic              reserveValidIn;
    logic [NR-1:0]     reserveMaskIn;
    logic [NR*DW-1:0]  regFileOut;
    logic [NR-1:0]     regInUseOut;
    logic              retireValidOut;
    logic [63:0]       retireRipOut;
    logic [31:0]       retireCountOut;
    logic              haltedOut;

    writeback_commit #(
        .NUM_REGS(NR), .REG_IDX_W(IW), .DATA_W(DW), .NUM_WB_PORTS(NP), .NUM_SRC(NS)
    ) dut (
        .clk(clk), .reset(reset), .wbValidIn(wbValidIn), .wbReadyOut(wbReadyOut),
        .killIn(killIn), .currentRipIn(currentRipIn), .srcRegIn(srcRegIn),
        .srcValidIn(srcValidIn), .destRegIn(destRegIn), .destValidIn(destValidIn),
        .resultIn(resultIn), .reserveValidIn(reserveValidIn), .reserveMaskIn(reserveMaskIn),
        .regFileOut(regFileOut), .regInUseOut(regInUseOut), .retireValidOut(retireValidOut),
        .retireRipOut(retireRipOut), .retireCountOut(retireCountOut), .haltedOut(haltedOut)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: architectural state updated once per clock from the presented instruction.
    logic [63:0] m_regs [NR];
    logic [NR-1:0] m_inuse;
    bit          m_halted;
    bit          m_retire;
    logic [63:0] m_rip;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NR; r++) m_regs[r] = '0;
            m_inuse = '0; m_halted = 0; m_retire = 0; m_rip = '0; m_cnt = '0;
        end else if (m_halted) begin
            m_retire = 0;
        end else begin
            logic [NR-1:0] rel;
            int idx;
            rel = '0;
            m_retire = wbValidIn;
            if (wbValidIn) begin
                for (int s = 0; s < NS; s++) begin
                    idx = int'(srcRegIn[s*IW +: IW]);
                    if (srcValidIn[s] && idx < NR) rel[idx] = 1'b1;
                end
                for (int p = 0; p < NP; p++) begin
                    idx = int'(destRegIn[p*IW +: IW]);
                    if (destValidIn[p] && idx < NR) begin
                        rel[idx]    = 1'b1;
                        m_regs[idx] = resultIn[p*DW +: DW];
                    end
                end
                m_rip = currentRipIn;
                m_cnt = m_cnt + 1;
                if (killIn) m_halted = 1;
            end
            m_inuse = (m_inuse & ~rel) | (reserveValidIn ? reserveMaskIn : '0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int r = 0; r < NR; r++) chk("model_reg", regFileOut[r*DW +: DW], m_regs[r]);
            chk("model_inuse",  64'(regInUseOut), 64'(m_inuse));
            chk("model_retire", 64'(retireValidOut), 64'(m_retire));
            chk("model_rip",    retireRipOut, m_rip);
            chk("model_cnt",    64'(retireCountOut), 64'(m_cnt));
            chk("model_halted", 64'(haltedOut), 64'(m_halted));
            chk("model_ready",  64'(wbReadyOut), 64'(!m_halted));
        end
    end

    function automatic logic [63:0] rf(input int r);
        return regFileOut[r*DW +: DW];
    endfunction

    task automatic idle();
        reset = 0; wbValidIn = 0; killIn = 0; currentRipIn = '0;
        srcRegIn = '0; srcValidIn = '0; destRegIn = '0; destValidIn = '0;
        resultIn = '0; reserveValidIn = 0; reserveMaskIn = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    task automatic rand_inputs(input bit allow_kill);
        wbValidIn      = ($urandom_range(3) != 0);
        killIn         = allow_kill && ($urandom_range(30) == 0);
        currentRipIn   = {$urandom, $urandom};
        srcRegIn       = NS*IW'($urandom);
        srcValidIn     = NS'($urandom);
        destRegIn      = NP*IW'($urandom);
        destValidIn    = NP'($urandom);
        resultIn       = {$urandom, $urandom, $urandom, $urandom};
        reserveValidIn = ($urandom_range(2) == 0);
        reserveMaskIn  = NR'($urandom);
        reset          = ($urandom_range(60) == 0);
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        cmp_en = 1;
        chk("reset_rf_zero", 64'(|regFileOut), 64'd0);
        chk("reset_ready", 64'(wbReadyOut), 64'd1);
        chk("reset_cnt", 64'(retireCountOut), 64'd0);

        // Reserve 1 and 3, then commit dest 3 releasing src 1.
        reserveValidIn = 1; reserveMaskIn = 12'h00A;
        cyc();
        chk("t1_reserved", 64'(regInUseOut), 64'h00A);
        wbValidIn = 1; currentRipIn = 64'h1000;
        destRegIn[3:0] = 4'd3; destValidIn = 2'b01; resultIn[63:0] = 64'hDEAD_BEEF;
        srcRegIn[3:0] = 4'd1; srcValidIn = 2'b01;
        cyc();
        chk("t1_reg3", rf(3), 64'hDEAD_BEEF);
        chk("t1_inuse", 64'(regInUseOut), 64'h000);
        chk("t1_retire", 64'(retireValidOut), 64'd1);
        chk("t1_cnt", 64'(retireCountOut), 64'd1);
        chk("t1_rip", retireRipOut, 64'h1000);
        cyc();
        chk("t1_pulse_end", 64'(retireValidOut), 64'd0);

        // Dual port write, then both ports to one register.
        wbValidIn = 1; destRegIn = {4'd2, 4'd0}; destValidIn = 2'b11;
        resultIn = {64'h20, 64'h10};
        cyc();
        chk("t2_reg0", rf(0), 64'h10);
        chk("t2_reg2", rf(2), 64'h20);
        wbValidIn = 1; destRegIn = {4'd5, 4'd5}; destValidIn = 2'b11;
        resultIn = {64'hBB, 64'hAA};
        cyc();
        chk("t2_reg5_port1_wins", rf(5), 64'hBB);

        // Release and reserve of reg 4 in the same cycle.
        wbValidIn = 1; destRegIn[3:0] = 4'd4; destValidIn = 2'b01; resultIn[63:0] = 64'h44;
        reserveValidIn = 1; reserveMaskIn = 12'h010;
        cyc();
        chk("t3_inuse4", 64'(regInUseOut[4]), 64'd1);
        chk("t3_reg4", rf(4), 64'h44);
        chk("t3_cnt", 64'(retireCountOut), 64'd4);

        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b0);
            cyc();
        end

        // Reset coinciding with a valid write drops the write.
        reset = 1; wbValidIn = 1; destRegIn[3:0] = 4'd1; destValidIn = 2'b01; resultIn[63:0] = 64'h99;
        cyc();
        chk("t5_rf_zero", 64'(|regFileOut), 64'd0);
        chk("t5_inuse_zero", 64'(regInUseOut), 64'd0);
        chk("t5_ready", 64'(wbReadyOut), 64'd1);

        // Out-of-range indices touch nothing.
        reserveValidIn = 1; reserveMaskIn = 12'h800;
        cyc();
        wbValidIn = 1; destRegIn = {4'd15, 4'd12}; destValidIn = 2'b11;
        resultIn = {64'h5555, 64'h6666}; srcRegIn = {4'd13, 4'd14}; srcValidIn = 2'b11;
        cyc();
        chk("t6_oor_rf", 64'(|regFileOut), 64'd0);
        chk("t6_oor_inuse", 64'(regInUseOut), 64'h800);

        // Counter wrap from all ones.
        cmp_en = 0;
        m_cnt = 32'hFFFF_FFFF;
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        cmp_en = 1;
        wbValidIn = 1;
        cyc();
        chk("t6_cnt_wrap", 64'(retireCountOut), 64'd0);
        chk("t6_wrap_retire", 64'(retireValidOut), 64'd1);

        // Kill commits and halts; later traffic ignored.
        wbValidIn = 1; killIn = 1; destRegIn[3:0] = 4'd6; destValidIn = 2'b01; resultIn[63:0] = 64'h77;
        cyc();
        chk("t4_reg6", rf(6), 64'h77);
        chk("t4_cnt", 64'(retireCountOut), 64'd1);
        chk("t4_halted", 64'(haltedOut), 64'd1);
        chk("t4_ready", 64'(wbReadyOut), 64'd0);
        wbValidIn = 1; destRegIn[3:0] = 4'd7; destValidIn = 2'b01; resultIn[63:0] = 64'h123;
        reserveValidIn = 1; reserveMaskIn = 12'h100;
        cyc();
        chk("t4_reg7_frozen", rf(7), 64'h0);
        chk("t4_inuse8", 64'(regInUseOut[8]), 64'd0);
        chk("t4_no_retire", 64'(retireValidOut), 64'd0);
        chk("t4_still_halted", 64'(haltedOut), 64'd1);

        reset = 1;
        cyc();
        chk("t5_halt_rf_zero", 64'(|regFileOut), 64'd0);
        chk("t5_halt_cleared", 64'(haltedOut), 64'd0);
        chk("t5_halt_ready", 64'(wbReadyOut), 64'd1);

        for (int i = 0; i < 600; i++) begin
            rand_inputs(1'b1);
            cyc();
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Registered, parametrised writeback/commit stage for the out-of-order-free x86-64 pipeline; it sits between execute/memory and the register file/scoreboard.
- Owns the architectural register file and the register in-use bitmap (scoreboard).
- Commits up to NUM_WB_PORTS results per instruction, releases source/destination reservations, and accepts new reservations from decode.
- Halts the machine cleanly on a kill instruction rather than stopping simulation.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- REG_IDX_W, 4, register index width; NUM_REGS must be <= 2**REG_IDX_W.
- DATA_W, 64, register/result width.
- NUM_WB_PORTS, 2, destination write ports per instruction (primary + special, e.g. RDX for mul/div).
- NUM_SRC, 2, source-register release slots per instruction.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- wbValidIn  in  1  instruction present at writeback.
- wbReadyOut  out  1  stage can accept; 0 only when halted.
- killIn  in  1  instruction is a halt/kill; qualified by wbValidIn.
- currentRipIn  in  64  RIP of the instruction.
- srcRegIn  in  NUM_SRC*REG_IDX_W  source indices to release.
- srcValidIn  in  NUM_SRC  per-source valid.
- destRegIn  in  NUM_WB_PORTS*REG_IDX_W  destination indices.
- destValidIn  in  NUM_WB_PORTS  per-port write enable.
- resultIn  in  NUM_WB_PORTS*DATA_W  per-port result.
- reserveValidIn  in  1  decode reservation strobe.
- reserveMaskIn  in  NUM_REGS  registers decode is claiming.
- regFileOut  out  NUM_REGS*DATA_W  flattened register file, registered.
- regInUseOut  out  NUM_REGS  scoreboard bitmap, registered.
- retireValidOut  out  1  pulse: one instruction committed last cycle.
- retireRipOut  out  64  RIP of the last committed instruction.
- retireCountOut  out  32  committed-instruction counter.
- haltedOut  out  1  machine halted.

Behaviour:
- Accept = wbValidIn & wbReadyOut, sampled at posedge clk.
- Commit latency 1 cycle: regFileOut and regInUseOut reflect the commit in the cycle after accept. No internal bypass; decode must bypass itself or stall on regInUseOut.
- Writes: for each port p with destValidIn[p], regFile[destRegIn[p]] <= resultIn[p]. When two valid ports target the same register, the higher port index wins.
- Scoreboard next state, applied in this order:
  - Start from the current bitmap.
  - Clear bits for every valid src and every valid dest of the accepted instruction.
  - OR in reserveMaskIn if reserveValidIn.
  - A reserve and a release of the same register in one cycle leaves the bit at 1.
- Reservations are honoured even when no instruction is accepted. In HALTED, reservations are ignored.
- Indices >= NUM_REGS are ignored for writes and scoreboard updates; there is no wrap into the array.
- retireValidOut = 1 for exactly one cycle after each accept, else 0. retireRipOut is loaded on accept and holds otherwise.
- retireCountOut increments on each accept and wraps 0xFFFFFFFF -> 0.
- FSM has two states:
  - RUN: wbReadyOut = 1. An accept with killIn = 1 still commits its writes, releases and count, then moves to HALTED.
  - HALTED: wbReadyOut = 0, haltedOut = 1, all inputs ignored, register state frozen. Only reset exits.
- killIn with wbValidIn = 0 has no effect.
- Reset (synchronous, any state, including mid-stream):
  - Register file and bitmap all 0.
  - retireValidOut = 0, retireRipOut = 0, retireCountOut = 0, haltedOut = 0, state = RUN.
  - wbReadyOut = 1 from the first cycle after reset.
  - An instruction presented in the reset cycle is dropped.

Test Plan:
1. Reset, then accept dest0 = 3, result 0xDEAD_BEEF, src0 = 1 valid, bits 1 and 3 preset via reserve -> next cycle: reg3 = 0xDEADBEEF, regInUse[1] = regInUse[3] = 0, retireValidOut pulse, retireCountOut = 1.
2. Dest0 = 0 (RAX) = 0x10 and dest1 = 2 (RDX) = 0x20 together; then both ports to reg 5 with 0xAA (port 0) and 0xBB (port 1) -> reg0 = 0x10, reg2 = 0x20; reg5 = 0xBB.
3. Same cycle: release reg 4 via dest, reserveMaskIn bit 4 -> regInUse[4] = 1; reg4 value updated.
4. Accept with killIn = 1 and dest 6 = 0x77 -> reg6 = 0x77, count incremented, haltedOut = 1, wbReadyOut = 0. A subsequent valid write to reg 7 and a reserve of reg 8 are both ignored.
5. Reset asserted in HALTED, and separately in the same cycle as a valid write -> all registers and the bitmap are 0, write dropped, wbReadyOut = 1 next cycle.
6. Preload retireCountOut to 0xFFFFFFFF (back-to-back accepts or force) and accept once more -> 0. Dest index 15 with NUM_REGS = 12 -> no register changes.
